// File: rtl/pp_pipeline_accel_stream2axi_burst_writer_if.sv
// ---------------------------------------------------------------------------
// pp_pipeline_accel_stream2axi_burst_writer_if
// AXI4 master bundle used by the stream-to-AXI burst writer.
//   AW : AWVALID/AWREADY, AWADDR, AWLEN, AWSIZE, AWBURST
//   W  : WVALID/WREADY, WDATA, WSTRB, WLAST
//   B  : BVALID/BREADY, BRESP
//   AR/R : request-side outputs only (writer ties them inactive)
// master modport = writer side, slave modport = memory/interconnect side.
// ---------------------------------------------------------------------------
interface pp_pipeline_accel_stream2axi_burst_writer_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64
);
   logic                AWVALID;
   logic                AWREADY;
   logic [ADDR_W-1:0]   AWADDR;
   logic [7:0]          AWLEN;
   logic [2:0]          AWSIZE;
   logic [1:0]          AWBURST;

   logic                WVALID;
   logic                WREADY;
   logic [DATA_W-1:0]   WDATA;
   logic [DATA_W/8-1:0] WSTRB;
   logic                WLAST;

   logic                BVALID;
   logic                BREADY;
   logic [1:0]          BRESP;

   logic                ARVALID;
   logic [ADDR_W-1:0]   ARADDR;
   logic [7:0]          ARLEN;
   logic [2:0]          ARSIZE;
   logic [1:0]          ARBURST;
   logic                RREADY;

   modport master (
      output AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST,
      input  AWREADY,
      output WVALID, WDATA, WSTRB, WLAST,
      input  WREADY,
      input  BVALID, BRESP,
      output BREADY,
      output ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, RREADY
   );

   modport slave (
      input  AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST,
      output AWREADY,
      input  WVALID, WDATA, WSTRB, WLAST,
      output WREADY,
      output BVALID, BRESP,
      input  BREADY,
      input  ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, RREADY
   );
endinterface

// File: rtl/pp_pipeline_accel_stream2axi_burst_writer.sv
// ---------------------------------------------------------------------------
// pp_pipeline_accel_stream2axi_burst_writer
// Drains num_beats words from a first-word-fall-through FIFO and writes them
// as AXI4 INCR bursts starting at base_addr. Bursts never cross a 4 KB page
// and never exceed MAX_BURST beats; at most MAX_OUTSTANDING bursts may await
// their B response.
// Ports:
//   ap_clk, ap_rst          clock, synchronous active-high reset
//   ap_start/done/idle/ready ap_ctrl_hs block handshake
//   base_addr, num_beats    transfer descriptor, sampled on accepted start
//   sdata_dout/empty_n/read FWFT FIFO read port
//   m_axi                   AXI4 master (write only; AR/R tied off)
//   bresp_err               sticky error flag, only with
//                           PP_STREAM2AXI_BRESP_ERR_EN defined
// ---------------------------------------------------------------------------
module pp_pipeline_accel_stream2axi_burst_writer #(
   parameter int DATA_W          = 64,
   parameter int ADDR_W          = 64,
   parameter int MAX_BURST       = 16,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              ap_start,
   output logic              ap_done,
   output logic              ap_idle,
   output logic              ap_ready,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [18:0]       num_beats,
   input  logic [DATA_W-1:0] sdata_dout,
   input  logic              sdata_empty_n,
   output logic              sdata_read,
   pp_pipeline_accel_stream2axi_burst_writer_if.master m_axi
`ifdef PP_STREAM2AXI_BRESP_ERR_EN
   ,
   output logic              bresp_err
`endif
);

   localparam int SIZE_LOG = $clog2(DATA_W / 8);
   localparam int OUT_W    = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] aw_addr;      // address of the next AW burst
   logic [18:0]       aw_rem;       // beats not yet covered by an accepted AW
   logic [OUT_W-1:0]  outstanding;  // AW accepted, B not yet seen
   logic [ADDR_W-1:0] w_addr;       // start address of the burst W is filling
   logic [18:0]       w_rem;        // beats not yet accepted on W
   logic [8:0]        w_cnt;        // beat index within the current W burst
   logic [OUT_W-1:0]  w_avail;      // AW-accepted bursts whose W is incomplete

   // Burst length as a pure function of (address, remaining): the W side
   // replays the same sequence as AW to locate WLAST without a length FIFO.
   function automatic logic [8:0] calc_len(input logic [ADDR_W-1:0] a,
                                           input logic [18:0] rem);
      logic [12:0] bytes_to_4k;
      logic [18:0] to4k;
      logic [18:0] len;
      bytes_to_4k = 13'h1000 - {1'b0, a[11:0]};
      to4k        = 19'(bytes_to_4k >> SIZE_LOG);
      len         = 19'(MAX_BURST);
      if (rem < len)  len = rem;
      if (to4k < len) len = to4k;
      return len[8:0];
   endfunction

   logic              aw_hs, w_hs, b_hs, w_pending, w_last_beat;
   logic [8:0]        aw_len, w_len;
   logic [ADDR_W-1:0] aw_addr_nx;
   logic [18:0]       aw_rem_nx;
   logic [OUT_W-1:0]  out_nx;

   assign aw_len      = calc_len(aw_addr, aw_rem);
   assign w_len       = calc_len(w_addr, w_rem);
   assign w_last_beat = (w_cnt == w_len - 9'd1);
   assign w_pending   = (state == S_RUN) && (w_avail != '0) && !ap_rst;

   assign m_axi.WVALID = w_pending & sdata_empty_n;
   assign m_axi.WLAST  = w_pending & w_last_beat;
   assign m_axi.WDATA  = sdata_dout;
   assign m_axi.WSTRB  = '1;
   assign sdata_read   = m_axi.WVALID & m_axi.WREADY;

   assign m_axi.AWSIZE  = 3'(SIZE_LOG);
   assign m_axi.AWBURST = 2'b01;

   assign m_axi.ARVALID = 1'b0;
   assign m_axi.ARADDR  = '0;
   assign m_axi.ARLEN   = '0;
   assign m_axi.ARSIZE  = '0;
   assign m_axi.ARBURST = '0;
   assign m_axi.RREADY  = 1'b0;

   assign ap_idle = ap_rst | ((state == S_IDLE) && !ap_start);

   assign aw_hs = m_axi.AWVALID & m_axi.AWREADY;
   assign w_hs  = sdata_read;
   assign b_hs  = m_axi.BVALID & m_axi.BREADY;

   always_comb begin
      aw_addr_nx = aw_addr;
      aw_rem_nx  = aw_rem;
      if (aw_hs) begin
         aw_addr_nx = aw_addr + (ADDR_W'(aw_len) << SIZE_LOG);
         aw_rem_nx  = aw_rem - 19'(aw_len);
      end
      case ({aw_hs, b_hs})
         2'b10:   out_nx = outstanding + OUT_W'(1);
         2'b01:   out_nx = outstanding - OUT_W'(1);
         default: out_nx = outstanding;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state         <= S_IDLE;
         aw_addr       <= '0;
         aw_rem        <= '0;
         outstanding   <= '0;
         w_addr        <= '0;
         w_rem         <= '0;
         w_cnt         <= '0;
         w_avail       <= '0;
         m_axi.AWVALID <= 1'b0;
         m_axi.AWADDR  <= '0;
         m_axi.AWLEN   <= '0;
         m_axi.BREADY  <= 1'b0;
         ap_done       <= 1'b0;
         ap_ready      <= 1'b0;
      end else begin
         ap_done  <= 1'b0;
         ap_ready <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ap_start) begin
                  ap_ready    <= 1'b1;
                  aw_addr     <= base_addr;
                  aw_rem      <= num_beats;
                  w_addr      <= base_addr;
                  w_rem       <= num_beats;
                  w_cnt       <= '0;
                  w_avail     <= '0;
                  outstanding <= '0;
                  if (num_beats == '0) begin
                     state   <= S_DONE;
                     ap_done <= 1'b1;
                  end else begin
                     state         <= S_RUN;
                     m_axi.AWVALID <= 1'b1;
                     m_axi.AWADDR  <= base_addr;
                     m_axi.AWLEN   <= 8'(calc_len(base_addr, num_beats) - 9'd1);
                     m_axi.BREADY  <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               aw_addr       <= aw_addr_nx;
               aw_rem        <= aw_rem_nx;
               outstanding   <= out_nx;
               m_axi.AWVALID <= (aw_rem_nx != '0) && (out_nx < MAX_OUT);
               if (aw_rem_nx != '0) begin
                  m_axi.AWADDR <= aw_addr_nx;
                  m_axi.AWLEN  <= 8'(calc_len(aw_addr_nx, aw_rem_nx) - 9'd1);
               end
               case ({aw_hs, w_hs && w_last_beat})
                  2'b10:   w_avail <= w_avail + OUT_W'(1);
                  2'b01:   w_avail <= w_avail - OUT_W'(1);
                  default: w_avail <= w_avail;
               endcase
               if (w_hs) begin
                  if (w_last_beat) begin
                     w_addr <= w_addr + (ADDR_W'(w_len) << SIZE_LOG);
                     w_rem  <= w_rem - 19'(w_len);
                     w_cnt  <= '0;
                     if (w_rem == 19'(w_len)) state <= S_DRAIN;
                  end else begin
                     w_cnt <= w_cnt + 9'd1;
                  end
               end
            end
            S_DRAIN: begin
               outstanding <= out_nx;
               if (out_nx == '0) begin
                  state        <= S_DONE;
                  ap_done      <= 1'b1;
                  m_axi.BREADY <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef PP_STREAM2AXI_BRESP_ERR_EN
   always_ff @(posedge ap_clk) begin
      if (ap_rst)
         bresp_err <= 1'b0;
      else if (b_hs && (m_axi.BRESP != 2'b00))
         bresp_err <= 1'b1;
      else if ((state == S_IDLE) && ap_start)
         bresp_err <= 1'b0;
   end
`else
   logic unused_bresp;
   assign unused_bresp = ^m_axi.BRESP;
`endif

endmodule

// File: tb/tb_pp_pipeline_accel_stream2axi_burst_writer.sv
// ---------------------------------------------------------------------------
// tb_pp_pipeline_accel_stream2axi_burst_writer
// Directed bench: FWFT FIFO model, AXI write slave with optional ready gaps
// and withheld B responses, handshake logs checked against hand-derived
// burst layouts.
// ---------------------------------------------------------------------------
module tb_pp_pipeline_accel_stream2axi_burst_writer;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 64;

   logic              ap_clk = 1'b0;
   logic              ap_rst = 1'b1;
   logic              ap_start = 1'b0;
   logic              ap_done, ap_idle, ap_ready;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [18:0]       num_beats = '0;
   logic [DATA_W-1:0] sdata_dout;
   logic              sdata_empty_n;
   logic              sdata_read;
`ifdef PP_STREAM2AXI_BRESP_ERR_EN
   logic              bresp_err;
`endif

   pp_pipeline_accel_stream2axi_burst_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) axi ();

   pp_pipeline_accel_stream2axi_burst_writer #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(16), .MAX_OUTSTANDING(4)
   ) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
      .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
      .base_addr(base_addr), .num_beats(num_beats),
      .sdata_dout(sdata_dout), .sdata_empty_n(sdata_empty_n),
      .sdata_read(sdata_read), .m_axi(axi)
`ifdef PP_STREAM2AXI_BRESP_ERR_EN
      , .bresp_err(bresp_err)
`endif
   );

   always #5 ap_clk = ~ap_clk;

   // bench controls (written only by the main initial block)
   logic        mon_clr = 1'b1;
   logic        rnd_mode = 1'b0;
   logic        hold_b = 1'b0;
   int unsigned fifo_len = 0;
   int unsigned cur_tag = 0;

   // gap drivers
   logic gap_e = 1'b1;
   always @(negedge ap_clk) begin
      if (rnd_mode) begin
         gap_e       = ($urandom_range(0, 3) != 0);
         axi.WREADY  = ($urandom_range(0, 2) != 0);
         axi.AWREADY = ($urandom_range(0, 1) != 0);
      end else begin
         gap_e       = 1'b1;
         axi.WREADY  = 1'b1;
         axi.AWREADY = 1'b1;
      end
   end

   function automatic logic [63:0] mk_word(input int unsigned t, input int unsigned k);
      return {16'hC0DE, 16'(t), 32'(k)};
   endfunction

   // monitor / FIFO model / B responder
   int unsigned       aw_n, w_n, b_n, done_n, rd_ptr, pend;
   logic              aw_seen, w_seen, bvalid_r;
   logic [ADDR_W-1:0] aw_addr_log [16];
   logic [7:0]        aw_len_log  [16];
   logic [63:0]       w_data_log  [256];
   logic              w_last_log  [256];

   assign sdata_dout    = mk_word(cur_tag, rd_ptr);
   assign sdata_empty_n = (rd_ptr < fifo_len) && gap_e;
   assign axi.BVALID    = bvalid_r;
   assign axi.BRESP     = 2'b00;

   always @(posedge ap_clk) begin
      int unsigned pend_n;
      if (mon_clr) begin
         aw_n <= 0; w_n <= 0; b_n <= 0; done_n <= 0; rd_ptr <= 0; pend <= 0;
         aw_seen <= 1'b0; w_seen <= 1'b0; bvalid_r <= 1'b0;
      end else begin
         if (axi.AWVALID) aw_seen <= 1'b1;
         if (axi.WVALID)  w_seen  <= 1'b1;
         if (axi.AWVALID && axi.AWREADY) begin
            if (aw_n < 16) begin
               aw_addr_log[aw_n] <= axi.AWADDR;
               aw_len_log[aw_n]  <= axi.AWLEN;
            end
            aw_n <= aw_n + 1;
         end
         if (axi.WVALID && axi.WREADY) begin
            if (w_n < 256) begin
               w_data_log[w_n] <= axi.WDATA;
               w_last_log[w_n] <= axi.WLAST;
            end
            w_n <= w_n + 1;
         end
         if (sdata_read) rd_ptr <= rd_ptr + 1;
         if (ap_done) done_n <= done_n + 1;
         pend_n = pend;
         if (axi.WVALID && axi.WREADY && axi.WLAST) pend_n = pend_n + 1;
         if (bvalid_r && axi.BREADY) begin
            pend_n = pend_n - 1;
            b_n <= b_n + 1;
         end
         pend     <= pend_n;
         bvalid_r <= (!hold_b && pend_n != 0) || (bvalid_r && !axi.BREADY);
      end
   end

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic start_xfer(input logic [ADDR_W-1:0] a, input int unsigned n,
                             input int unsigned t, input string tag);
      @(negedge ap_clk);
      base_addr = a;
      num_beats = 19'(n);
      fifo_len  = n;
      cur_tag   = t;
      mon_clr   = 1'b1;
      @(negedge ap_clk);
      mon_clr  = 1'b0;
      ap_start = 1'b1;
      #1;
      chk({tag, ".idle_start"}, 64'(ap_idle), 64'd0);
      @(posedge ap_clk);
      #1;
      chk({tag, ".ap_ready"}, 64'(ap_ready), 64'd1);
      chk({tag, ".awvalid_first"}, 64'(axi.AWVALID), 64'(n != 0));
      @(negedge ap_clk);
      ap_start = 1'b0;
   endtask

   task automatic wait_done(input int unsigned budget, input string tag);
      bit seen = 1'b0;
      for (int unsigned i = 0; i < budget; i++) begin
         @(posedge ap_clk);
         #1;
         if (ap_done) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, ".done_seen"}, 64'(seen), 64'd1);
      repeat (3) @(negedge ap_clk);
      chk({tag, ".done_pulses"}, 64'(done_n), 64'd1);
   endtask

   // Checks W stream: data in FIFO order, WLAST exactly at burst ends.
   task automatic check_stream(input string tag, input int unsigned n,
                               input int unsigned lens [4], input int unsigned nb);
      bit          exp_last [256];
      int unsigned pos = 0;
      int unsigned derr = 0;
      int unsigned lerr = 0;
      for (int unsigned k = 0; k < 256; k++) exp_last[k] = 1'b0;
      for (int unsigned i = 0; i < nb; i++) begin
         pos = pos + lens[i];
         exp_last[pos-1] = 1'b1;
      end
      for (int unsigned k = 0; k < n && k < 256; k++) begin
         if (w_data_log[k] !== mk_word(cur_tag, k)) derr++;
         if (w_last_log[k] !== exp_last[k]) lerr++;
      end
      chk({tag, ".w_count"}, 64'(w_n), 64'(n));
      chk({tag, ".rd_count"}, 64'(rd_ptr), 64'(n));
      chk({tag, ".data_errs"}, 64'(derr), 64'd0);
      chk({tag, ".wlast_errs"}, 64'(lerr), 64'd0);
   endtask

   initial begin
      int unsigned lens [4];

      // reset state
      repeat (3) @(posedge ap_clk);
      #1;
      chk("rst.awvalid", 64'(axi.AWVALID), 64'd0);
      chk("rst.wvalid", 64'(axi.WVALID), 64'd0);
      chk("rst.wlast", 64'(axi.WLAST), 64'd0);
      chk("rst.bready", 64'(axi.BREADY), 64'd0);
      chk("rst.sdata_read", 64'(sdata_read), 64'd0);
      chk("rst.ap_done", 64'(ap_done), 64'd0);
      chk("rst.ap_ready", 64'(ap_ready), 64'd0);
      chk("rst.ap_idle", 64'(ap_idle), 64'd1);
      chk("rst.arvalid", 64'(axi.ARVALID), 64'd0);
      @(negedge ap_clk);
      ap_rst = 1'b0;
      @(negedge ap_clk);
      chk("idle.ap_idle", 64'(ap_idle), 64'd1);

      // 40 beats at 0x1000 -> 16,16,8
      start_xfer(64'h1000, 40, 1, "a");
      wait_done(500, "a");
      chk("a.aw_n", 64'(aw_n), 64'd3);
      chk("a.aw0_addr", aw_addr_log[0], 64'h1000);
      chk("a.aw1_addr", aw_addr_log[1], 64'h1080);
      chk("a.aw2_addr", aw_addr_log[2], 64'h1100);
      chk("a.aw0_len", 64'(aw_len_log[0]), 64'd15);
      chk("a.aw1_len", 64'(aw_len_log[1]), 64'd15);
      chk("a.aw2_len", 64'(aw_len_log[2]), 64'd7);
      chk("a.awsize", 64'(axi.AWSIZE), 64'd3);
      chk("a.awburst", 64'(axi.AWBURST), 64'd1);
      chk("a.wstrb", 64'(axi.WSTRB), 64'hFF);
      chk("a.b_n", 64'(b_n), 64'd3);
      lens = '{16, 16, 8, 0};
      check_stream("a", 40, lens, 3);

      // 4 beats at 0x0FF8 -> 1 beat to the page end, then 3
      start_xfer(64'h0FF8, 4, 2, "b");
      wait_done(200, "b");
      chk("b.aw_n", 64'(aw_n), 64'd2);
      chk("b.aw0_addr", aw_addr_log[0], 64'h0FF8);
      chk("b.aw0_len", 64'(aw_len_log[0]), 64'd0);
      chk("b.aw1_addr", aw_addr_log[1], 64'h1000);
      chk("b.aw1_len", 64'(aw_len_log[1]), 64'd2);
      lens = '{1, 3, 0, 0};
      check_stream("b", 4, lens, 2);

      // zero beats: no traffic, ap_done in the cycle after acceptance
      start_xfer(64'h2000, 0, 3, "c");
      chk("c.ap_done_now", 64'(ap_done), 64'd1);
      @(posedge ap_clk);
      #1;
      chk("c.ap_done_gone", 64'(ap_done), 64'd0);
      repeat (5) @(negedge ap_clk);
      chk("c.aw_seen", 64'(aw_seen), 64'd0);
      chk("c.w_seen", 64'(w_seen), 64'd0);
      chk("c.done_pulses", 64'(done_n), 64'd1);

      // 128 beats with B withheld: AW stalls at 4 outstanding
      hold_b = 1'b1;
      start_xfer(64'h0, 128, 4, "d");
      repeat (300) @(negedge ap_clk);
      chk("d.aw_n_held", 64'(aw_n), 64'd4);
      chk("d.w_n_held", 64'(w_n), 64'd64);
      chk("d.done_held", 64'(done_n), 64'd0);
      chk("d.b_n_held", 64'(b_n), 64'd0);
      hold_b = 1'b0;
      wait_done(1000, "d");
      chk("d.aw_n", 64'(aw_n), 64'd8);
      chk("d.b_n", 64'(b_n), 64'd8);
      chk("d.aw7_addr", aw_addr_log[7], 64'h380);

      // random FIFO/WREADY/AWREADY gaps, 50 beats crossing 0x1000
      rnd_mode = 1'b1;
      start_xfer(64'h0F00, 50, 5, "e");
      wait_done(3000, "e");
      rnd_mode = 1'b0;
      chk("e.aw_n", 64'(aw_n), 64'd4);
      chk("e.aw2_addr", aw_addr_log[2], 64'h1000);
      chk("e.aw3_len", 64'(aw_len_log[3]), 64'd1);
      lens = '{16, 16, 16, 2};
      check_stream("e", 50, lens, 4);

      // reset mid-burst, then a single-beat transfer
      start_xfer(64'h3000, 40, 6, "f");
      repeat (8) @(negedge ap_clk);
      ap_rst  = 1'b1;
      mon_clr = 1'b1;
      @(posedge ap_clk);
      #1;
      chk("f.rst_awvalid", 64'(axi.AWVALID), 64'd0);
      chk("f.rst_wvalid", 64'(axi.WVALID), 64'd0);
      chk("f.rst_bready", 64'(axi.BREADY), 64'd0);
      chk("f.rst_ap_idle", 64'(ap_idle), 64'd1);
      @(negedge ap_clk);
      ap_rst = 1'b0;
      @(negedge ap_clk);
      chk("f.idle_after", 64'(ap_idle), 64'd1);
      start_xfer(64'h4000, 1, 7, "g");
      wait_done(200, "g");
      chk("g.aw_n", 64'(aw_n), 64'd1);
      chk("g.aw0_addr", aw_addr_log[0], 64'h4000);
      chk("g.aw0_len", 64'(aw_len_log[0]), 64'd0);
      chk("g.b_n", 64'(b_n), 64'd1);
      lens = '{1, 0, 0, 0};
      check_stream("g", 1, lens, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pp_pipeline_accel_stream2axi_burst_writer.md
PP_PIPELINE_ACCEL_STREAM2AXI_BURST_WRITER -- requirements
Module: pp_pipeline_accel_stream2axi_burst_writer

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning W beat width in bits (power of two, 32..512).
REQ-002 SHALL have parameter ADDR_W, default 64, meaning AXI address width.
REQ-003 SHALL have parameter MAX_BURST, default 16, meaning maximum beats per AW burst (1..256).
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, meaning maximum bursts issued but not yet B-acknowledged.
REQ-005 SHALL use one clock and a synchronous, active-high reset; the ports are listed below.
REQ-006 ap_clk  in  1  clock; all state on the rising edge.
REQ-007 ap_rst  in  1  synchronous active-high reset.
REQ-008 ap_start in 1 / ap_done out 1 / ap_idle out 1 / ap_ready out 1  block-level ap_ctrl_hs handshake.
REQ-009 base_addr  in  ADDR_W  byte address of the first beat, aligned to DATA_W/8; sampled on start.
REQ-010 num_beats  in  19  beats to transfer; sampled on start.
REQ-011 sdata_dout in DATA_W / sdata_empty_n in 1 / sdata_read out 1  first-word-fall-through FIFO read port.
REQ-012 m_axi_AW*  out  AWVALID 1, AWADDR ADDR_W, AWLEN 8, AWSIZE 3, AWBURST 2; AWREADY in 1.
REQ-013 m_axi_W*  out  WVALID 1, WDATA DATA_W, WSTRB DATA_W/8, WLAST 1; WREADY in 1.
REQ-014 m_axi_B*  BVALID in 1, BRESP in 2, BREADY out 1.
REQ-015 AR/R channels SHALL be tied inactive (ARVALID=0, RREADY=0, other AR outputs 0).

Function
REQ-016 States SHALL be IDLE, RUN, DRAIN, DONE; ap_start in IDLE -> RUN with ap_ready pulsed for one cycle.
REQ-017 num_beats==0 SHALL go IDLE -> DONE, with no AXI traffic and ap_done asserted the next cycle.
REQ-018 Each burst length SHALL be min(MAX_BURST, remaining beats, beats to next 4 KB boundary); AWLEN=len-1.
REQ-019 AWSIZE SHALL be log2(DATA_W/8), AWBURST=INCR (2'b01), WSTRB all ones.
REQ-020 AWVALID SHALL assert in RUN while bursts remain and outstanding<MAX_OUTSTANDING; AW fields stable until AWREADY.
REQ-021 First AWVALID SHALL assert the cycle after the start is accepted.
REQ-022 W beats SHALL issue only for bursts whose AW has been accepted, in order; WVALID=sdata_empty_n while such a beat is pending.
REQ-023 WDATA SHALL equal sdata_dout; sdata_read SHALL equal WVALID & WREADY, so one FIFO word is consumed per accepted beat.
REQ-024 WLAST SHALL assert on the final beat of each burst only.
REQ-025 BREADY SHALL be 1 in RUN and DRAIN; outstanding count +1 on AW handshake, -1 on B handshake; simultaneous events leave it unchanged.
REQ-026 After the final W beat is accepted, RUN -> DRAIN; DRAIN -> DONE when outstanding reaches 0.
REQ-027 ap_done SHALL pulse one cycle in DONE; DONE -> IDLE the following cycle.
REQ-028 ap_idle SHALL be 1 only in IDLE with ap_start low.
REQ-029 Address SHALL advance by len*(DATA_W/8) per accepted AW, with ADDR_W-bit wrap-around.

Reset
REQ-030 ap_rst SHALL force IDLE; clear counters; drive AWVALID, WVALID, WLAST, BREADY, sdata_read, ap_done, ap_ready to 0; drive ap_idle to 1.
REQ-031 Reset mid-transfer SHALL abandon the transfer without waiting for pending B responses.

Configuration
REQ-032 With PP_STREAM2AXI_BRESP_ERR_EN defined, output bresp_err (1 bit) SHALL latch 1 on any B handshake with BRESP!=OKAY, clear on accepted ap_start, and reset to 0.
REQ-033 Without PP_STREAM2AXI_BRESP_ERR_EN, the bresp_err port SHALL be absent and BRESP SHALL be ignored.

Verification
REQ-034 base 0x1000, num_beats=40, defaults -> three bursts: AWLEN 15,15,7; AWADDR 0x1000,0x1080,0x1100; WLAST on beats 16,32,40.
REQ-035 base 0x0FF8, num_beats=4 -> two bursts: AWLEN 0 at 0x0FF8, then AWLEN 2 at 0x1000.
REQ-036 num_beats=0 -> no AWVALID or WVALID; ap_done one cycle after start.
REQ-037 num_beats=128, B responses withheld -> exactly 4 AW handshakes until the first B; ap_done only after 8 B handshakes.
REQ-038 Random sdata_empty_n and WREADY gaps -> WDATA sequence equals FIFO order with no loss or duplication; sdata_read count equals num_beats.
REQ-039 ap_rst asserted mid-burst, then new start with num_beats=1 -> single AWLEN 0 burst with WLAST and a correct ap_done.
